fp16_norm_arbiter: RTL and testbench

Shared, multi-cycle normalizer for two FP requesters: A (adder path) and B (multiplier path). It accepts raw {sign, exponent, mantissa-with-carry} results and normalizes them iteratively, one shift per cycle. Carry, zero, subnormal and overflow cases are each handled. Requesters are arbitrated round-robin, and results return over a valid/ready port tagged with the requester ID.

---
 rtl/fp16_norm_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_fp16_norm_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_norm_arbiter.sv
// Shared iterative normalizer for two FP requesters (adder A, multiplier B).
// Round-robin grant in IDLE, one normalization step per cycle, valid/ready result port.
module fp16_norm_arbiter #(
  parameter int MB = 11,
  parameter int EB = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          A_VALID,
  output logic          A_READY,
  input  logic          A_SIGN,
  input  logic [EB-1:0] A_EXP,
  input  logic [MB:0]   A_MANT,
  input  logic          B_VALID,
  output logic          B_READY,
  input  logic          B_SIGN,
  input  logic [EB-1:0] B_EXP,
  input  logic [MB:0]   B_MANT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_SIGN,
  output logic [EB-1:0] OUT_EXP,
  output logic [MB-1:0] OUT_MANT,
  output logic          OUT_ID,
  output logic          OUT_OVF,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [EB:0] E_ONE = {{EB{1'b0}}, 1'b1};
  localparam logic [EB:0] E_MAX = {1'b0, {EB{1'b1}}};

  state_t        state_r, state_s;
  logic          last_id_r, last_id_s;
  logic          sign_r, sign_s;
  logic          id_r, id_s;
  logic [MB:0]   mant_r, mant_s;
  logic [EB:0]   e_r, e_s;
  logic          busy_r, busy_s;
  logic          out_valid_r, out_valid_s;
  logic          out_sign_r, out_sign_s;
  logic [EB-1:0] out_exp_r, out_exp_s;
  logic [MB-1:0] out_mant_r, out_mant_s;
  logic          out_id_r, out_id_s;
  logic          out_ovf_r, out_ovf_s;

  logic          grant_b_s;
  logic          a_ready_s, b_ready_s;
  logic          sel_sign_s;
  logic [EB-1:0] sel_exp_s;
  logic [MB:0]   sel_mant_s;
  logic [EB:0]   e_inc_s;
  logic          norm_fin_s;
  logic          norm_ovf_s;
  logic [EB-1:0] norm_exp_s;
  logic [MB-1:0] norm_mant_s;

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    grant_b_s  = B_VALID && (!A_VALID || !last_id_r);
    a_ready_s  = (state_r == IDLE) && A_VALID && !grant_b_s;
    b_ready_s  = (state_r == IDLE) && grant_b_s;
    sel_sign_s = grant_b_s ? B_SIGN : A_SIGN;
    sel_exp_s  = grant_b_s ? B_EXP  : A_EXP;
    sel_mant_s = grant_b_s ? B_MANT : A_MANT;
  end

  // One normalization step: decide whether this cycle finalizes and what it produces.
  always_comb begin
    e_inc_s     = e_r + E_ONE;
    norm_fin_s  = 1'b1;
    norm_ovf_s  = 1'b0;
    norm_exp_s  = {EB{1'b0}};
    norm_mant_s = {MB{1'b0}};
    if (mant_r[MB]) begin
      if (e_inc_s == E_MAX) begin
        norm_exp_s  = {EB{1'b1}};
        norm_mant_s = {MB{1'b0}};
        norm_ovf_s  = 1'b1;
      end else begin
        norm_exp_s  = e_inc_s[EB-1:0];
        norm_mant_s = mant_r[MB:1];
      end
    end else if (mant_r == {(MB+1){1'b0}}) begin
      norm_exp_s  = {EB{1'b0}};
      norm_mant_s = {MB{1'b0}};
    end else if (mant_r[MB-1]) begin
      norm_exp_s  = e_r[EB-1:0];
      norm_mant_s = mant_r[MB-1:0];
    end else if (e_r == E_ONE) begin
      // Exponent floor reached without a hidden bit: emit as subnormal.
      norm_exp_s  = {EB{1'b0}};
      norm_mant_s = mant_r[MB-1:0];
    end else begin
      norm_fin_s = 1'b0;
    end
  end

  // Next-state and next-register logic for the IDLE/NORM/DONE controller.
  always_comb begin
    state_s     = state_r;
    last_id_s   = last_id_r;
    sign_s      = sign_r;
    id_s        = id_r;
    mant_s      = mant_r;
    e_s         = e_r;
    out_valid_s = out_valid_r;
    out_sign_s  = out_sign_r;
    out_exp_s   = out_exp_r;
    out_mant_s  = out_mant_r;
    out_id_s    = out_id_r;
    out_ovf_s   = out_ovf_r;
    case (state_r)
      IDLE: begin
        if (a_ready_s || b_ready_s) begin
          state_s   = NORM;
          sign_s    = sel_sign_s;
          mant_s    = sel_mant_s;
          id_s      = grant_b_s;
          last_id_s = grant_b_s;
          e_s       = (sel_exp_s == {EB{1'b0}}) ? E_ONE : {1'b0, sel_exp_s};
        end else begin
          state_s = IDLE;
        end
      end
      NORM: begin
        if (norm_fin_s) begin
          state_s     = DONE;
          out_valid_s = 1'b1;
          out_sign_s  = sign_r;
          out_id_s    = id_r;
          out_exp_s   = norm_exp_s;
          out_mant_s  = norm_mant_s;
          out_ovf_s   = norm_ovf_s;
        end else begin
          mant_s = {mant_r[MB-1:0], 1'b0};
          e_s    = e_r - E_ONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      last_id_r   <= 1'b1;
      sign_r      <= 1'b0;
      id_r        <= 1'b0;
      mant_r      <= {(MB+1){1'b0}};
      e_r         <= {(EB+1){1'b0}};
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_sign_r  <= 1'b0;
      out_exp_r   <= {EB{1'b0}};
      out_mant_r  <= {MB{1'b0}};
      out_id_r    <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_id_r   <= last_id_s;
      sign_r      <= sign_s;
      id_r        <= id_s;
      mant_r      <= mant_s;
      e_r         <= e_s;
      busy_r      <= busy_s;
      out_valid_r <= out_valid_s;
      out_sign_r  <= out_sign_s;
      out_exp_r   <= out_exp_s;
      out_mant_r  <= out_mant_s;
      out_id_r    <= out_id_s;
      out_ovf_r   <= out_ovf_s;
    end
  end

  assign A_READY   = a_ready_s;
  assign B_READY   = b_ready_s;
  assign BUSY      = busy_r;
  assign OUT_VALID = out_valid_r;
  assign OUT_SIGN  = out_sign_r;
  assign OUT_EXP   = out_exp_r;
  assign OUT_MANT  = out_mant_r;
  assign OUT_ID    = out_id_r;
  assign OUT_OVF   = out_ovf_r;

endmodule

// File: tb/tb_fp16_norm_arbiter.sv
// Self-checking bench for fp16_norm_arbiter: directed cases, arbitration, backpressure,
// mid-job reset and randomized traffic checked against a leading-one based model.
module tb_fp16_norm_arbiter;
  localparam int MB = 11;
  localparam int EB = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          A_VALID = 1'b0, A_SIGN = 1'b0;
  logic [EB-1:0] A_EXP = '0;
  logic [MB:0]   A_MANT = '0;
  logic          B_VALID = 1'b0, B_SIGN = 1'b0;
  logic [EB-1:0] B_EXP = '0;
  logic [MB:0]   B_MANT = '0;
  logic          OUT_READY = 1'b1;
  logic          A_READY, B_READY, OUT_VALID, OUT_SIGN, OUT_ID, OUT_OVF, BUSY;
  logic [EB-1:0] OUT_EXP;
  logic [MB-1:0] OUT_MANT;

  fp16_norm_arbiter #(.MB(MB), .EB(EB)) dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_SIGN(A_SIGN), .A_EXP(A_EXP), .A_MANT(A_MANT),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_SIGN(B_SIGN), .B_EXP(B_EXP), .B_MANT(B_MANT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SIGN(OUT_SIGN), .OUT_EXP(OUT_EXP),
    .OUT_MANT(OUT_MANT), .OUT_ID(OUT_ID), .OUT_OVF(OUT_OVF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ovf;
    logic [4:0]  e;
    logic [10:0] m;
    logic [3:0]  k;
  } res_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state
  logic        m_busy = 1'b0, m_last = 1'b1, m_sign = 1'b0, m_id = 1'b0;
  int          m_due = 0;
  res_t        m_res = '0;
  logic        a_fire = 1'b0, b_fire = 1'b0;
  logic        ea, eb, ev, hold_pend = 1'b0;
  logic [19:0] hold_vec = '0, cur_vec;
  int          grant_log[$];

  // Result from leading-one position: shift as far as needed or until exponent floor.
  function automatic res_t model(input logic [4:0] ex, input logic [11:0] mt);
    res_t r;
    int   e, p, need, avail, k;
    r = '0;
    e = (ex == 5'd0) ? 1 : int'(ex);
    if (mt[11]) begin
      e = e + 1;
      if (e == 31) begin
        r.ovf = 1'b1;
        r.e   = 5'd31;
      end else begin
        r.e = e[4:0];
        r.m = mt[11:1];
      end
    end else if (mt != 12'd0) begin
      p = 0;
      for (int i = 0; i < 11; i++) if (mt[i]) p = i;
      need  = 10 - p;
      avail = e - 1;
      k     = (need < avail) ? need : avail;
      r.k   = 4'(k);
      r.m   = 11'(mt << k);
      r.e   = (k == need) ? 5'(e - k) : 5'd0;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Compare process: every falling edge checks DUT against the model, then advances the model.
  always @(negedge CLK) begin
    if (RST) begin
      m_busy = 1'b0; m_last = 1'b1; a_fire = 1'b0; b_fire = 1'b0; hold_pend = 1'b0;
      chk("reset_outputs", {OUT_VALID, OUT_SIGN, OUT_EXP, OUT_MANT, OUT_ID, OUT_OVF, BUSY, A_READY, B_READY}, 32'd0);
    end else begin
      ev = m_busy && (cyc >= m_due);
      cur_vec = {OUT_VALID, OUT_SIGN, OUT_ID, OUT_OVF, OUT_EXP, OUT_MANT, 1'b0};
      chk("busy", BUSY, m_busy);
      chk("out_valid", OUT_VALID, ev);
      if (ev) chk("result", {OUT_SIGN, OUT_ID, OUT_OVF, OUT_EXP, OUT_MANT}, {m_sign, m_id, m_res.ovf, m_res.e, m_res.m});
      if (hold_pend) chk("hold_stable", cur_vec, hold_vec);
      hold_pend = ev && !OUT_READY;
      hold_vec  = cur_vec;
      ea = !m_busy && A_VALID && (!B_VALID || m_last);
      eb = !m_busy && B_VALID && (!A_VALID || !m_last);
      chk("a_ready", A_READY, ea);
      chk("b_ready", B_READY, eb);
      chk("ready_excl", {A_READY && B_READY, (A_READY || B_READY) && BUSY}, 32'd0);
      a_fire = ea;
      b_fire = eb;
      if (ea || eb) begin
        m_res  = eb ? model(B_EXP, B_MANT) : model(A_EXP, A_MANT);
        m_sign = eb ? B_SIGN : A_SIGN;
        m_id   = eb;
        m_last = eb;
        m_due  = cyc + 2 + int'(m_res.k);
        m_busy = 1'b1;
        grant_log.push_back(int'(eb));
      end else if (ev && OUT_READY) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_payload(output logic s, output logic [4:0] e, output logic [11:0] m);
    s = 1'($urandom % 2);
    e = 5'($urandom_range(0, 30));
    m = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
  endtask

  task automatic send_job(input logic id, input logic s, input logic [4:0] e, input logic [11:0] m);
    bit done = 0;
    if (id) begin B_SIGN = s; B_EXP = e; B_MANT = m; B_VALID = 1'b1; end
    else    begin A_SIGN = s; A_EXP = e; A_MANT = m; A_VALID = 1'b1; end
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if ((id && b_fire) || (!id && a_fire)) done = 1;
    end
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    if (!done) timeout("send_job");
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (!m_busy) done = 1;
    end
    if (!done) timeout("wait_idle");
  endtask

  initial begin
    // Literal pins on the model itself
    chk("model_norm",   model(5'd15, 12'h400), {1'b0, 5'd15, 11'h400, 4'd0});
    chk("model_carry",  model(5'd15, 12'hC00), {1'b0, 5'd16, 11'h600, 4'd0});
    chk("model_ovf",    model(5'd30, 12'h800), {1'b1, 5'd31, 11'h000, 4'd0});
    chk("model_shift5", model(5'd10, 12'h020), {1'b0, 5'd5,  11'h400, 4'd5});
    chk("model_shift10",model(5'd20, 12'h001), {1'b0, 5'd10, 11'h400, 4'd10});
    chk("model_subn",   model(5'd3,  12'h040), {1'b0, 5'd0,  11'h100, 4'd2});
    chk("model_zero",   model(5'd9,  12'h000), {1'b0, 5'd0,  11'h000, 4'd0});

    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    // Both requesters held valid from reset: grants alternate A,B,A,B
    grant_log.delete();
    rand_payload(A_SIGN, A_EXP, A_MANT);
    rand_payload(B_SIGN, B_EXP, B_MANT);
    A_VALID = 1'b1; B_VALID = 1'b1;
    for (int i = 0; i < 300 && grant_log.size() < 6; i++) begin
      step();
      if (a_fire) rand_payload(A_SIGN, A_EXP, A_MANT);
      if (b_fire) rand_payload(B_SIGN, B_EXP, B_MANT);
    end
    A_VALID = 1'b0; B_VALID = 1'b0;
    if (grant_log.size() < 6) timeout("arb_grants");
    else for (int i = 0; i < 6; i++) chk("arb_order", grant_log[i], i % 2);
    wait_idle();

    // Directed cases
    send_job(1'b0, 1'b0, 5'd15, 12'h400); wait_idle();
    send_job(1'b0, 1'b0, 5'd15, 12'hC00); wait_idle();
    send_job(1'b0, 1'b0, 5'd30, 12'h800); wait_idle();
    send_job(1'b0, 1'b0, 5'd29, 12'h900); wait_idle();
    send_job(1'b1, 1'b0, 5'd10, 12'h020); wait_idle();
    send_job(1'b1, 1'b0, 5'd20, 12'h001); wait_idle();
    send_job(1'b0, 1'b0, 5'd3,  12'h040); wait_idle();
    send_job(1'b1, 1'b1, 5'd7,  12'h000); wait_idle();
    send_job(1'b0, 1'b0, 5'd0,  12'h400); wait_idle();
    send_job(1'b1, 1'b1, 5'd1,  12'h155); wait_idle();

    // Backpressure: result held for three cycles
    OUT_READY = 1'b0;
    send_job(1'b0, 1'b1, 5'd12, 12'h100);
    for (int i = 0; i < 50 && !OUT_VALID; i++) step();
    repeat (3) step();
    chk("bp_valid_held", OUT_VALID, 1'b1);
    OUT_READY = 1'b1;
    wait_idle();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!A_VALID || a_fire) begin A_VALID = 1'($urandom % 2); rand_payload(A_SIGN, A_EXP, A_MANT); end
      if (!B_VALID || b_fire) begin B_VALID = 1'($urandom % 2); rand_payload(B_SIGN, B_EXP, B_MANT); end
      OUT_READY = ($urandom % 4) != 0;
    end
    A_VALID = 1'b0; B_VALID = 1'b0; OUT_READY = 1'b1;
    wait_idle();

    // Reset in the middle of a long normalization; next tie goes to A
    send_job(1'b1, 1'b0, 5'd20, 12'h001);
    repeat (3) step();
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    grant_log.delete();
    rand_payload(A_SIGN, A_EXP, A_MANT);
    rand_payload(B_SIGN, B_EXP, B_MANT);
    A_VALID = 1'b1; B_VALID = 1'b1;
    for (int i = 0; i < 20 && grant_log.size() < 1; i++) step();
    A_VALID = 1'b0; B_VALID = 1'b0;
    if (grant_log.size() < 1) timeout("post_reset_grant");
    else chk("post_reset_tie", grant_log[0], 0);
    wait_idle();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
